// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the seven-segment scan controller.
//   NDIG      - number of display digits
//   SEG_BLANK - active-low "all segments off" pattern (dp included)
//   dig_ent_t - one digit buffer entry {en, nib}
//   wr_req_t  - one requester's write request fields
//   hex2seg() - hex nibble to active-low segment pattern {dp,g..a}
package seg_pkg;

    localparam int         NDIG      = 8;
    localparam int         IDXW      = 3;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef struct packed {
        logic       en;
        logic [3:0] nib;
    } dig_ent_t;

    typedef struct packed {
        logic [IDXW-1:0] idx;
        logic [3:0]      data;
        logic            en;
    } wr_req_t;

    localparam dig_ent_t DIG_RST = '{en: 1'b0, nib: 4'h0};

    // dp (bit 7) stays off for every glyph
    function automatic logic [7:0] hex2seg(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_rr_arb.sv
// seg_rr_arb: 2-way round-robin arbiter for the digit buffer write port.
//   clk, rst   - clock, synchronous active-high reset
//   valid[1:0] - request lines (bit 0 = A, bit 1 = B)
//   grant[1:0] - one-hot (or zero) grant, combinational; forced 0 during rst
// Priority starts at A and passes to the other side after every grant.
module seg_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic prio_b;  // 1: B wins a tie

    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = prio_b ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            prio_b <= 1'b0;
        else if (grant[0])
            prio_b <= 1'b1;
        else if (grant[1])
            prio_b <= 1'b0;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 8-digit seven-segment controller.
//   clk, rst              - clock, synchronous active-high reset
//   a_valid/a_ready/...   - requester A write port (idx, data nibble, enable)
//   b_valid/b_ready/...   - requester B write port
//   blink_mask[7:0]       - per-digit blink enable
//   seg_sel[7:0]          - one-hot active-high digit select (registered)
//   seg_out[7:0]          - active-low segments {dp,g..a} (registered)
//   frame_done            - pulse in the first cycle digit 0 of a new frame shows
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [2:0] a_idx,
    input  logic [3:0] a_data,
    input  logic       a_en,
    input  logic       b_valid,
    output logic       b_ready,
    input  logic [2:0] b_idx,
    input  logic [3:0] b_data,
    input  logic       b_en,
    input  logic [7:0] blink_mask,
    output logic [7:0] seg_sel,
    output logic [7:0] seg_out,
    output logic       frame_done
);

    localparam int             DW         = $clog2(SCAN_DIV);
    localparam int             FW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [FW-1:0]  FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NDIG - 1);

    // ---------------- write arbitration ----------------
    logic [1:0] grant;
    wr_req_t    req_a, req_b, wr;
    logic       wr_en;

    assign req_a = '{idx: a_idx, data: a_data, en: a_en};
    assign req_b = '{idx: b_idx, data: b_data, en: b_en};

    seg_rr_arb u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid ({b_valid, a_valid}),
        .grant (grant)
    );

    assign a_ready = grant[0];
    assign b_ready = grant[1];
    assign wr_en   = |grant;
    assign wr      = grant[1] ? req_b : req_a;

    // ---------------- digit buffer ----------------
    dig_ent_t dbuf [NDIG];

    for (genvar d = 0; d < NDIG; d++) begin : g_dig
        always_ff @(posedge clk) begin
            if (rst)
                dbuf[d] <= DIG_RST;
            else if (wr_en && wr.idx == IDXW'(d))
                dbuf[d] <= '{en: wr.en, nib: wr.data};
        end
    end

    // ---------------- scan / blink timing ----------------
    logic [DW-1:0]   dwell;
    logic [IDXW-1:0] scan_idx;
    logic [FW-1:0]   frame_cnt;
    logic            blink_phase;
    logic            wrap_q;      // scan_idx just wrapped 7->0
    logic            dwell_end, wrap;

    assign dwell_end = (dwell == DWELL_LAST);
    assign wrap      = dwell_end && (scan_idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell       <= '0;
            scan_idx    <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            dwell  <= dwell_end ? '0 : dwell + 1'b1;
            wrap_q <= wrap;
            if (dwell_end)
                scan_idx <= scan_idx + 1'b1;
            if (wrap) begin
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // ---------------- registered outputs ----------------
    // Outputs trail scan_idx by one cycle; frame_done is delayed from the
    // wrap edge by the same cycle so it lines up with seg_sel showing digit 0.
    dig_ent_t cur;
    logic     blank;

    assign cur   = dbuf[scan_idx];
    assign blank = !cur.en || (blink_mask[scan_idx] && blink_phase);

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_sel    <= 8'h01;
            seg_out    <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            seg_sel    <= 8'h01 << scan_idx;
            seg_out    <= blank ? SEG_BLANK : hex2seg(cur.nib);
            frame_done <= wrap_q;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed scoreboard bench for seg_scan_ctrl
// (SCAN_DIV=4, BLINK_FRAMES=2, so a frame is 32 cycles).
// Time t counts clock edges since the first reset release; digit d of
// frame f (f from 0) is on seg_sel for t = 32f+4d+1 .. 32f+4d+4.
module tb_seg_scan_ctrl;

    localparam int T0 = 3;  // absolute edge count at which t = 0

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, a_ready, a_en, b_valid, b_ready, b_en;
    logic [2:0] a_idx, b_idx;
    logic [3:0] a_data, b_data;
    logic [7:0] blink_mask, seg_sel, seg_out;
    logic       frame_done;

    seg_scan_ctrl #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_idx      (a_idx),
        .a_data     (a_data),
        .a_en       (a_en),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_idx      (b_idx),
        .b_data     (b_data),
        .b_en       (b_en),
        .blink_mask (blink_mask),
        .seg_sel    (seg_sel),
        .seg_out    (seg_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         t;
        bit         is_rdy;
        logic [7:0] sel;
        logic [7:0] out;
        logic       fd;
        logic       ar;
        logic       br;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 0;
    bit   flushed = 0;

    task automatic ed(input int t, input logic [7:0] s, input logic [7:0] o, input logic f);
        q.push_back('{t: t + T0, is_rdy: 1'b0, sel: s, out: o, fd: f, ar: 1'b0, br: 1'b0});
    endtask

    task automatic er(input int t, input logic ar, input logic br);
        q.push_back('{t: t + T0, is_rdy: 1'b1, sel: 8'h00, out: 8'h00, fd: 1'b0, ar: ar, br: br});
    endtask

    task automatic chk(input string n, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s t=%0d got %h want %h", n, cyc - T0, act, want);
        end
    endtask

    // Monitor: compare every expectation due at this cycle; leftovers at the
    // end are expectations the run never reached.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].t == cyc) begin
                if (q[i].is_rdy) begin
                    chk("a_ready", {7'd0, a_ready}, {7'd0, q[i].ar});
                    chk("b_ready", {7'd0, b_ready}, {7'd0, q[i].br});
                end else begin
                    chk("seg_sel", seg_sel, q[i].sel);
                    chk("seg_out", seg_out, q[i].out);
                    chk("frame_done", {7'd0, frame_done}, {7'd0, q[i].fd});
                end
                q.delete(i);
            end
        end
        if (done && !flushed) begin
            for (int i = 0; i < q.size(); i++) begin
                errors++;
                $display("FAIL unreached t=%0d got none want check", q[i].t - T0);
            end
            flushed = 1;
        end
    end

    task automatic go(input int t);
        while (cyc != t + T0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drv(input logic av, input logic [2:0] ai, input logic [3:0] ad, input logic ae,
                       input logic bv, input logic [2:0] bi, input logic [3:0] bd, input logic be);
        a_valid = av; a_idx = ai; a_data = ad; a_en = ae;
        b_valid = bv; b_idx = bi; b_data = bd; b_en = be;
    endtask

    initial begin
        rst = 1'b1;
        blink_mask = 8'h08;
        drv(1, 0, 0, 0, 1, 0, 0, 0);
        ed(-2, 8'h01, 8'hFF, 0);   // reset state
        er(-2, 0, 0);              // no grants while in reset
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0);

        // scan pattern and buffer-driven display expectations
        ed(1, 8'h01, 8'hFF, 0);   ed(2, 8'h01, 8'hFF, 0);
        ed(3, 8'h01, 8'h92, 0);   ed(4, 8'h01, 8'h92, 0);
        ed(5, 8'h02, 8'hFF, 0);   ed(8, 8'h02, 8'hFF, 0);
        ed(9, 8'h04, 8'hF8, 0);   ed(10, 8'h04, 8'hF8, 0);
        ed(11, 8'h04, 8'hC6, 0);  ed(12, 8'h04, 8'hC6, 0);
        ed(13, 8'h08, 8'hFF, 0);  ed(17, 8'h10, 8'hFF, 0);
        ed(20, 8'h10, 8'hFF, 0);  ed(21, 8'h20, 8'hFF, 0);
        ed(29, 8'h80, 8'hFF, 0);  ed(32, 8'h80, 8'hFF, 0);
        ed(33, 8'h01, 8'h92, 1);  ed(34, 8'h01, 8'h92, 0);
        ed(37, 8'h02, 8'hB0, 0);  ed(41, 8'h04, 8'hC6, 0);
        ed(45, 8'h08, 8'h8E, 0);  ed(49, 8'h10, 8'hFF, 0);
        ed(64, 8'h80, 8'hFF, 0);  ed(65, 8'h01, 8'h92, 1);
        ed(67, 8'h01, 8'h92, 0);  ed(69, 8'h02, 8'hB0, 0);
        ed(77, 8'h08, 8'hFF, 0);  ed(97, 8'h01, 8'h92, 1);
        ed(109, 8'h08, 8'hFF, 0); ed(141, 8'h08, 8'h8E, 0);
        ed(149, 8'h20, 8'hFF, 0);

        go(1);  drv(1, 0, 4'h5, 1, 0, 0, 0, 0); er(1, 1, 0);
        go(2);  drv(0, 0, 0, 0, 0, 0, 0, 0);
        go(6);  drv(0, 0, 0, 0, 1, 2, 4'h7, 1); er(6, 0, 1);
        go(7);  drv(0, 0, 0, 0, 0, 0, 0, 0);
        // both requesting for three cycles: A, B, A
        go(8);  drv(1, 1, 4'h1, 1, 1, 2, 4'hC, 1); er(8, 1, 0); er(9, 0, 1); er(10, 1, 0);
        go(9);  drv(1, 1, 4'h3, 1, 1, 2, 4'hC, 1);
        go(10); drv(1, 1, 4'h3, 1, 1, 2, 4'hD, 1);
        go(11); drv(0, 0, 0, 0, 0, 0, 0, 0);
        go(14); drv(1, 4, 4'h8, 0, 0, 0, 0, 0); er(14, 1, 0);
        go(15); drv(0, 0, 0, 0, 1, 3, 4'hF, 1); er(15, 0, 1);
        go(16); drv(0, 0, 0, 0, 0, 0, 0, 0);
        go(148); drv(1, 6, 4'h9, 1, 0, 0, 0, 0); er(148, 1, 0);
        go(149); drv(0, 0, 0, 0, 0, 0, 0, 0);
        // one-cycle reset with digit 5 selected
        go(150); rst = 1'b1; drv(1, 6, 4'h2, 1, 0, 0, 0, 0); er(150, 0, 0);
        ed(151, 8'h01, 8'hFF, 0); ed(152, 8'h01, 8'hFF, 0);
        ed(154, 8'h01, 8'hFF, 0); ed(156, 8'h02, 8'hFF, 0);
        ed(181, 8'h80, 8'hF9, 0); ed(183, 8'h80, 8'hF9, 0);
        ed(184, 8'h01, 8'hFF, 1);
        go(151); rst = 1'b0; drv(1, 7, 4'h1, 1, 1, 7, 4'h4, 1); er(151, 1, 0);
        go(152); drv(0, 0, 0, 0, 0, 0, 0, 0);
        go(186);
        done = 1;
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed controller for the board's 8-digit seven-segment display. It shares the digit buffer between two write requesters (A, B) using round-robin arbitration and scans the digits one at a time with a programmable dwell. It also applies per-digit enable and blink, and drives one registered digit-select/segment pair. It sits between the counter/shift-register datapaths and the display pins, replacing statically wired per-digit decoders.

## Interface
Parameters:
- SCAN_DIV, 1000, clock cycles each digit stays selected (legal values ≥ 2)
- BLINK_FRAMES, 64, full scan frames per blink half-period (legal values ≥ 1)

Ports:
- clk  in  1  single clock; everything is on its rising edge
- rst  in  1  synchronous, active-high reset
- a_valid  in  1  requester A write request
- a_ready  out  1  A granted this cycle (combinational)
- a_idx  in  3  digit index 0..7 for A
- a_data  in  4  hex nibble for A
- a_en  in  1  digit enable written with A's nibble
- b_valid, b_ready, b_idx, b_data, b_en: same as A, for requester B
- blink_mask  in  8  bit i=1 makes digit i blink; sampled every cycle
- seg_sel  out  8  one-hot, active-high digit select
- seg_out  out  8  active-low segment pattern; bit7=dp (always 1), bits6..0 = g..a
- frame_done  out  1  one-cycle pulse when the scan wraps from digit 7 to 0

## Operation
- Buffer: 8 entries, each {en, nibble[3:0]}. Reset value: all en=0, nibble=0.
- Arbitration:
  - A handshake completes when x_valid && x_ready in the same cycle.
  - At most one grant per cycle.
  - If only one requester is valid, that requester is granted.
  - If both are valid, the requester holding priority is granted.
  - After any grant, priority passes to the other requester.
  - Priority resets to A.
  - A_ready and b_ready are 0 while rst is high.
- Write: on handshake, buf[idx] <= {en, data} at that clock edge. Writes to the same index from successive grants simply overwrite.
- Scan:
  - dwell counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1, dwell returns to 0 and scan_idx increments mod 8.
  - On the 7→0 wrap, the frame counter increments and frame_done pulses.
- Blink:
  - blink_phase toggles each time the frame counter reaches BLINK_FRAMES-1; the counter then clears.
  - blink_phase resets to 0 (visible).
- Decode (active-low):
  - 0..F map to C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
  - Blank is FF.
- Output pattern:
  - seg_out = FF if en=0, or if (blink_mask[scan_idx] && blink_phase).
  - Otherwise seg_out is the decoded nibble.
  - A disabled digit still receives its scan slot: seg_sel is asserted and seg_out = FF.

## Timing
- Reset values:
  - seg_sel = 8'h01, seg_out = 8'hFF, frame_done = 0
  - scan_idx = 0, dwell = 0, frame counter = 0, blink_phase = 0
- seg_sel, seg_out and frame_done are registered and are recomputed every cycle from the current scan_idx, buffer and blink state. seg_sel and seg_out always change on the same edge.
- Write latency: handshake in cycle k → buffer updated at edge end-of-k → seg_out reflects it at edge end-of-k+1, provided that digit is selected.
- Each digit is held for exactly SCAN_DIV cycles, so a frame is 8·SCAN_DIV cycles.
- frame_done is high for the single cycle in which seg_sel first shows digit 0 of a new frame. It is not asserted for the post-reset frame.
- Simultaneous write and scan of the same digit: the new value is shown one cycle later, with no glitch to other digits.
- Reset mid-operation, on the edge where rst is sampled high:
  - all state returns to reset values;
  - pending requests are dropped;
  - buffer contents are lost.
- blink_mask changes take effect on the next registered output update.

## Structure
- Package seg_pkg holds:
  - NDIG = 8;
  - the SEG_BLANK = 8'hFF constant;
  - the 16-entry hex-to-segment constant array / decode function;
  - a typedef for a buffer entry {en, nibble}.
- Sub-module seg_rr_arb is the 2-way round-robin arbiter (valid[1:0] → grant[1:0], with its priority flop).
- Scan counters, buffer and output registers live in seg_scan_ctrl.

## Test plan
- Reset, then idle for 8·SCAN_DIV cycles → seg_sel walks 01,02,…,80 with SCAN_DIV cycles each; seg_out = FF throughout; frame_done pulses once at the wrap.
- A writes idx=0, data=5, en=1 while digit 0 is selected → a_ready=1 the same cycle; seg_out = 92 two edges after the handshake.
- A and B both valid for 3 cycles, writing idx 1 and idx 2 → grants in order A, B, A; priority alternates; final buf[1] equals A's last data.
- Digit 3 = F with en=1 and blink_mask=8'h08, BLINK_FRAMES=2 → digit 3 shows 8E for 2 frames, FF for 2 frames, then repeats; other digits are unaffected.
- Write idx=4, en=0 with data=8 → digit 4 slot shows FF while seg_sel=10.
- Assert rst for 1 cycle mid-frame with digit 5 selected → next cycle seg_sel=01, seg_out=FF, all digits blank, and priority is back to A.
